// File: rtl/circuit_sweep_checker_if.sv
// circuit_sweep_checker_if
//   Bundles the control, circuit-facing and result signals of the sweep checker.
//   master : the checker (drives abc_out and results, receives start/abort/de_in)
//   slave  : the environment (drives start/abort and the circuit response de_in)
//   start, abort     : run control (single-cycle start pulse, synchronous abort)
//   abc_out, de_in   : vector to the circuit {a,b,c} and its response {d,e}
//   busy, done, pass : run status
//   err_count, first_fail_valid/vec/de : mismatch statistics for the run
interface circuit_sweep_checker_if;
    logic       start;
    logic       abort;
    logic [2:0] abc_out;
    logic [1:0] de_in;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_count;
    logic       first_fail_valid;
    logic [2:0] first_fail_vec;
    logic [1:0] first_fail_de;

    modport master (
        input  start, abort, de_in,
        output abc_out, busy, done, pass, err_count,
               first_fail_valid, first_fail_vec, first_fail_de
    );

    modport slave (
        output start, abort, de_in,
        input  abc_out, busy, done, pass, err_count,
               first_fail_valid, first_fail_vec, first_fail_de
    );
endinterface

// File: rtl/circuit_sweep_checker.sv
// circuit_sweep_checker
//   Synthesizable stimulus/response engine for the 3-input, 2-output circuit
//   d = (a & b) | ~c, e = ~c. Steps abc through 0..7 (SWEEPS times), waits
//   SETTLE_CYCLES after each vector, samples de_in and counts mismatches.
// Parameters:
//   SETTLE_CYCLES : cycles between driving a vector and sampling (1..15)
//   SWEEPS        : full 0..7 sweeps per run (1..255)
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : circuit_sweep_checker_if.master (control, circuit bus, results)
module circuit_sweep_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned SWEEPS        = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    circuit_sweep_checker_if.master       bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_e;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0] LAST_SWEEP  = 8'(SWEEPS - 1);

    state_e     state_q, state_d;
    logic [2:0] abc_q, abc_d;
    logic [3:0] settle_q, settle_d;
    logic [7:0] sweep_q, sweep_d;
    logic [7:0] err_q, err_d;
    logic       ff_valid_q, ff_valid_d;
    logic [2:0] ff_vec_q, ff_vec_d;
    logic [1:0] ff_de_q, ff_de_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;

    logic [1:0] golden_de;
    logic       mismatch;

    // Expected circuit response for the vector currently driven.
    assign golden_de = {(abc_q[2] & abc_q[1]) | ~abc_q[0], ~abc_q[0]};
    assign mismatch  = (bus.de_in != golden_de);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            abc_q      <= '0;
            settle_q   <= '0;
            sweep_q    <= '0;
            err_q      <= '0;
            ff_valid_q <= 1'b0;
            ff_vec_q   <= '0;
            ff_de_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            abc_q      <= abc_d;
            settle_q   <= settle_d;
            sweep_q    <= sweep_d;
            err_q      <= err_d;
            ff_valid_q <= ff_valid_d;
            ff_vec_q   <= ff_vec_d;
            ff_de_q    <= ff_de_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        abc_d      = abc_q;
        settle_d   = settle_q;
        sweep_d    = sweep_q;
        err_d      = err_q;
        ff_valid_d = ff_valid_q;
        ff_vec_d   = ff_vec_q;
        ff_de_d    = ff_de_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    err_d      = '0;
                    ff_valid_d = 1'b0;
                    ff_vec_d   = '0;
                    ff_de_d    = '0;
                    abc_d      = '0;
                    sweep_d    = '0;
                    state_d    = S_DRIVE;
                end
            end
            S_DRIVE: begin
                settle_d = SETTLE_LOAD;
                state_d  = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_q == '0) begin
                    state_d = S_SAMPLE;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            S_SAMPLE: begin
                if (mismatch) begin
                    if (err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                    end
                    if (!ff_valid_q) begin
                        ff_valid_d = 1'b1;
                        ff_vec_d   = abc_q;
                        ff_de_d    = bus.de_in;
                    end
                end
                if (abc_q != 3'd7) begin
                    abc_d   = abc_q + 3'd1;
                    state_d = S_DRIVE;
                end else if (sweep_q != LAST_SWEEP) begin
                    abc_d   = '0;
                    sweep_d = sweep_q + 8'd1;
                    state_d = S_DRIVE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything above, including a same-cycle sample:
        // results keep the values they had before this cycle.
        if (bus.abort) begin
            state_d    = S_IDLE;
            abc_d      = '0;
            settle_d   = '0;
            sweep_d    = '0;
            err_d      = err_q;
            ff_valid_d = ff_valid_q;
            ff_vec_d   = ff_vec_q;
            ff_de_d    = ff_de_q;
        end
    end

    // Status flags are registered from the next state so they line up with it.
    always_comb begin
        busy_d = (state_d == S_DRIVE) || (state_d == S_SETTLE) || (state_d == S_SAMPLE);
        done_d = (state_d == S_DONE);
        pass_d = (state_d == S_DONE) && (err_d == '0);
    end

    assign bus.abc_out          = abc_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.pass             = pass_q;
    assign bus.err_count        = err_q;
    assign bus.first_fail_valid = ff_valid_q;
    assign bus.first_fail_vec   = ff_vec_q;
    assign bus.first_fail_de    = ff_de_q;

endmodule

// File: tb/tb_circuit_sweep_checker.sv
// tb_circuit_sweep_checker
//   Drives three checker instances (different SETTLE_CYCLES/SWEEPS) against a
//   behavioural circuit model with injectable faults, and predicts run
//   results from a sweep-level reference model.
module tb_circuit_sweep_checker;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    circuit_sweep_checker_if ia();
    circuit_sweep_checker_if ib();
    circuit_sweep_checker_if ic();

    circuit_sweep_checker #(.SETTLE_CYCLES(2), .SWEEPS(1))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    circuit_sweep_checker #(.SETTLE_CYCLES(1), .SWEEPS(40))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
    circuit_sweep_checker #(.SETTLE_CYCLES(3), .SWEEPS(100))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(ic));

    // Truth table of the correct circuit, indexed by {a,b,c}.
    logic [1:0] gold_tab [0:7] = '{2'b11, 2'b00, 2'b11, 2'b00,
                                   2'b11, 2'b00, 2'b11, 2'b10};

    // Circuit model for instance A: one faulty vector can be injected.
    logic       a_fault_en  = 1'b0;
    logic [2:0] a_fault_vec = '0;
    logic [1:0] a_fault_de  = '0;
    always_comb begin
        if (a_fault_en && ia.abc_out == a_fault_vec) ia.de_in = a_fault_de;
        else                                         ia.de_in = gold_tab[ia.abc_out];
    end
    // Instances B and C see a circuit whose outputs are stuck at 11.
    assign ib.de_in = 2'b11;
    assign ic.de_in = 2'b11;

    // Distinct vectors presented by instance A during a run.
    logic [2:0] seq_a [$];
    always @(negedge clk) begin
        if (ia.busy && (seq_a.size() == 0 || seq_a[$] != ia.abc_out))
            seq_a.push_back(ia.abc_out);
    end

    // Sweep-level reference: walk every vector of every sweep, count
    // responses that differ from the truth table, note the first one.
    function automatic void model_run(input int sweeps, input bit stuck,
                                      input bit fen, input logic [2:0] fvec,
                                      input logic [1:0] fde,
                                      output logic [15:0] exp_res);
        int         errs = 0;
        bit         fv = 1'b0;
        logic [2:0] fvv = '0;
        logic [1:0] fdd = '0;
        logic [1:0] resp;
        for (int s = 0; s < sweeps; s++) begin
            for (int v = 0; v < 8; v++) begin
                if (stuck)                        resp = 2'b11;
                else if (fen && 3'(v) == fvec)    resp = fde;
                else                              resp = gold_tab[v];
                if (resp != gold_tab[v]) begin
                    errs++;
                    if (!fv) begin
                        fv = 1'b1; fvv = 3'(v); fdd = resp;
                    end
                end
            end
        end
        if (errs > 255) errs = 255;
        // {err_count, ff_valid, ff_vec, ff_de, pass, done}
        exp_res = {8'(errs), fv, fvv, fdd, (errs == 0), 1'b1};
    endfunction

    function automatic logic [15:0] results_a();
        return {ia.err_count, ia.first_fail_valid, ia.first_fail_vec,
                ia.first_fail_de, ia.pass, ia.done};
    endfunction

    // Pulse start on A and count edges (start edge included) until done.
    // mid_start > 0 re-pulses start at that edge count while the run is busy.
    task automatic run_a(input int mid_start, output int cycles);
        int n;
        seq_a.delete();
        @(negedge clk); ia.start = 1'b1;
        @(negedge clk); ia.start = 1'b0; n = 1;
        while (!ia.done && n < 200) begin
            @(negedge clk);
            n++;
            ia.start = (n == mid_start);
        end
        ia.start = 1'b0;
        cycles = n;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        ia.start = 1'b0; ia.abort = 1'b0;
        ib.start = 1'b0; ib.abort = 1'b0;
        ic.start = 1'b0; ic.abort = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ia.abc_out, ia.busy, ia.done, results_a()} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_state: got abc=%0d busy=%b res=%h, want all 0",
                     ia.abc_out, ia.busy, results_a());
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({ia.busy, ia.done, ia.abc_out} !== 5'd0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%b done=%b abc=%0d, want 0 0 0",
                     ia.busy, ia.done, ia.abc_out);
        end
    endtask

    task automatic test_clean_run();
        int cyc;
        logic [15:0] exp;
        a_fault_en = 1'b0;
        run_a(0, cyc);
        model_run(1, 1'b0, 1'b0, 3'd0, 2'd0, exp);
        n_checks++;
        if (cyc !== 1 * 8 * (2 + 2) + 1) begin
            n_fail++;
            $display("FAIL clean_run_length: got %0d cycles, want %0d", cyc, 33);
        end
        n_checks++;
        if (results_a() !== exp) begin
            n_fail++;
            $display("FAIL clean_run_results: got %h, want %h", results_a(), exp);
        end
        n_checks++;
        if (seq_a.size() != 8) begin
            n_fail++;
            $display("FAIL clean_run_sequence_len: got %0d vectors, want 8", seq_a.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (seq_a[i] !== 3'(i)) begin
                    n_fail++;
                    $display("FAIL clean_run_sequence[%0d]: got %0d, want %0d", i, seq_a[i], i);
                end
            end
        end
    endtask

    task automatic test_fault_vec3();
        int cyc;
        logic [15:0] exp;
        a_fault_en = 1'b1; a_fault_vec = 3'd3; a_fault_de = 2'b10;
        run_a(0, cyc);
        model_run(1, 1'b0, 1'b1, 3'd3, 2'b10, exp);
        n_checks++;
        if (results_a() !== exp) begin
            n_fail++;
            $display("FAIL fault_vec3_results: got %h, want %h", results_a(), exp);
        end
        a_fault_en = 1'b0;
    endtask

    task automatic test_random_faults();
        int cyc;
        logic [15:0] exp;
        for (int k = 0; k < 8; k++) begin
            a_fault_en  = 1'b1;
            a_fault_vec = 3'($urandom_range(0, 7));
            a_fault_de  = 2'($urandom_range(0, 3));
            run_a(0, cyc);
            model_run(1, 1'b0, 1'b1, a_fault_vec, a_fault_de, exp);
            n_checks++;
            if (results_a() !== exp || cyc !== 33) begin
                n_fail++;
                $display("FAIL random_fault[%0d] vec=%0d de=%b: got res=%h cyc=%0d, want res=%h cyc=33",
                         k, a_fault_vec, a_fault_de, results_a(), cyc, exp);
            end
        end
        a_fault_en = 1'b0;
    endtask

    task automatic test_saturation();
        int n;
        logic [15:0] exp, got;
        // Instance B: 40 sweeps, no saturation.
        @(negedge clk); ib.start = 1'b1;
        @(negedge clk); ib.start = 1'b0; n = 1;
        while (!ib.done && n < 2000) begin @(negedge clk); n++; end
        model_run(40, 1'b1, 1'b0, 3'd0, 2'd0, exp);
        got = {ib.err_count, ib.first_fail_valid, ib.first_fail_vec,
               ib.first_fail_de, ib.pass, ib.done};
        n_checks++;
        if (n !== 40 * 8 * (1 + 2) + 1) begin
            n_fail++;
            $display("FAIL sweeps40_length: got %0d cycles, want %0d", n, 40 * 8 * 3 + 1);
        end
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL sweeps40_results: got %h, want %h", got, exp);
        end
        // Instance C: 100 sweeps, counter saturates.
        @(negedge clk); ic.start = 1'b1;
        @(negedge clk); ic.start = 1'b0; n = 1;
        while (!ic.done && n < 6000) begin @(negedge clk); n++; end
        model_run(100, 1'b1, 1'b0, 3'd0, 2'd0, exp);
        got = {ic.err_count, ic.first_fail_valid, ic.first_fail_vec,
               ic.first_fail_de, ic.pass, ic.done};
        n_checks++;
        if (n !== 100 * 8 * (3 + 2) + 1) begin
            n_fail++;
            $display("FAIL sweeps100_length: got %0d cycles, want %0d", n, 100 * 8 * 5 + 1);
        end
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL sweeps100_saturate: got %h, want %h", got, exp);
        end
    endtask

    task automatic test_abort();
        int n;
        int cyc;
        logic [15:0] exp;
        a_fault_en = 1'b1; a_fault_vec = 3'd2; a_fault_de = 2'b01;
        @(negedge clk); ia.start = 1'b1;
        @(negedge clk); ia.start = 1'b0; n = 0;
        while (ia.abc_out != 3'd5 && n < 100) begin @(negedge clk); n++; end
        n_checks++;
        if (n >= 100) begin
            n_fail++;
            $display("FAIL abort_reach_vec5: got timeout, want vector 5 reached");
        end
        @(negedge clk);            // now in SETTLE of vector 5
        ia.abort = 1'b1;
        @(negedge clk);
        ia.abort = 1'b0;
        n_checks++;
        if ({ia.busy, ia.done, ia.abc_out} !== 5'd0) begin
            n_fail++;
            $display("FAIL abort_to_idle: got busy=%b done=%b abc=%0d, want 0 0 0",
                     ia.busy, ia.done, ia.abc_out);
        end
        n_checks++;
        if ({ia.err_count, ia.first_fail_valid, ia.first_fail_vec, ia.first_fail_de}
            !== {8'd1, 1'b1, 3'd2, 2'b01}) begin
            n_fail++;
            $display("FAIL abort_keeps_results: got err=%0d ffv=%b vec=%0d de=%b, want 1 1 2 01",
                     ia.err_count, ia.first_fail_valid, ia.first_fail_vec, ia.first_fail_de);
        end
        a_fault_en = 1'b0;
        run_a(0, cyc);
        model_run(1, 1'b0, 1'b0, 3'd0, 2'd0, exp);
        n_checks++;
        if (results_a() !== exp) begin
            n_fail++;
            $display("FAIL rerun_after_abort: got %h, want %h", results_a(), exp);
        end
    endtask

    task automatic test_async_reset();
        int n;
        int cyc;
        logic [15:0] exp;
        a_fault_en = 1'b1; a_fault_vec = 3'd1; a_fault_de = 2'b11;
        @(negedge clk); ia.start = 1'b1;
        @(negedge clk); ia.start = 1'b0; n = 0;
        while (ia.abc_out != 3'd4 && n < 100) begin @(negedge clk); n++; end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ia.abc_out, ia.busy, ia.done, results_a()} !== 21'd0) begin
            n_fail++;
            $display("FAIL async_reset_midrun: got abc=%0d busy=%b res=%h, want all 0",
                     ia.abc_out, ia.busy, results_a());
        end
        @(negedge clk); rst_n = 1'b1;
        a_fault_en = 1'b0;
        run_a(0, cyc);
        model_run(1, 1'b0, 1'b0, 3'd0, 2'd0, exp);
        n_checks++;
        if (results_a() !== exp || cyc !== 33) begin
            n_fail++;
            $display("FAIL run_after_reset: got res=%h cyc=%0d, want res=%h cyc=33",
                     results_a(), cyc, exp);
        end
    endtask

    task automatic test_start_abort();
        int cyc;
        a_fault_en = 1'b0;
        run_a(10, cyc);
        n_checks++;
        if (cyc !== 33 || seq_a.size() != 8) begin
            n_fail++;
            $display("FAIL midrun_start_ignored: got cyc=%0d vectors=%0d, want 33 8",
                     cyc, seq_a.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (seq_a[i] !== 3'(i)) begin
                    n_fail++;
                    $display("FAIL midrun_sequence[%0d]: got %0d, want %0d", i, seq_a[i], i);
                end
            end
        end
        // From DONE: start and abort together.
        @(negedge clk); ia.start = 1'b1; ia.abort = 1'b1;
        @(negedge clk); ia.start = 1'b0; ia.abort = 1'b0;
        n_checks++;
        if ({ia.busy, ia.done, ia.pass, ia.abc_out} !== 6'd0) begin
            n_fail++;
            $display("FAIL start_abort_same_cycle: got busy=%b done=%b pass=%b abc=%0d, want idle",
                     ia.busy, ia.done, ia.pass, ia.abc_out);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if ({ia.busy, ia.done} !== 2'b00) begin
            n_fail++;
            $display("FAIL start_dropped: got busy=%b done=%b, want 0 0", ia.busy, ia.done);
        end
    endtask

    initial begin
        test_reset();
        test_clean_run();
        test_fault_vec3();
        test_random_faults();
        test_saturation();
        test_abort();
        test_async_reset();
        test_start_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/circuit_sweep_checker.md
Name: circuit_sweep_checker

Overview:
Hardware stimulus/response engine for the 3-input, 2-output logic circuit family (structural, dataflow and behavioural variants).
- Drives the circuit's a,b,c inputs through all 8 vectors in ascending order.
- Samples the returned d,e after a settle delay and compares them against the golden function d = (a & b) | ~c, e = ~c.
- Reports a pass/fail summary.
- Sits opposite the circuit under test, replacing the simulation-only sweep with a synthesizable, self-checking initiator usable on hardware.

Parameters:
SETTLE_CYCLES, 2, clock cycles between applying a vector and sampling de_in (legal range 1..15)
SWEEPS, 1, number of full 0..7 sweeps per run (legal range 1..255)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  single-cycle pulse; begins a run from IDLE or DONE
abort  input  1  synchronous; ends the current run and returns to IDLE without asserting done
abc_out  output  3  vector driven to circuit {a,b,c}; a is the MSB
de_in  input  2  circuit response {d,e}; d is the MSB
busy  output  1  high in DRIVE/SETTLE/SAMPLE
done  output  1  high in DONE state
pass  output  1  valid while done; 1 iff err_count == 0
err_count  output  8  mismatching samples this run, saturating at 255
first_fail_valid  output  1  a mismatch has been captured this run
first_fail_vec  output  3  abc of the first mismatch
first_fail_de  output  2  de_in observed at the first mismatch

Behaviour:
Reset (rst_n low, asynchronous):
- state=IDLE; abc_out=0; busy=0; done=0; pass=0; err_count=0.
- first_fail_valid=0; first_fail_vec=0; first_fail_de=0.
- Internal settle counter and sweep counter = 0.
- Reset mid-run abandons the run immediately; no partial results are kept.

FSM states: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
- IDLE: start=1 -> DRIVE. Also clears err_count and first_fail_*, and sets abc_out=0 and sweep=0.
- DRIVE (1 cycle): abc_out holds the current vector; load settle counter with SETTLE_CYCLES-1 -> SETTLE.
- SETTLE: decrement the counter each cycle; at 0 -> SAMPLE. Vector-to-sample latency = SETTLE_CYCLES+1 cycles after abc_out changes.
- SAMPLE (1 cycle): compare de_in with golden(abc_out).
  - On mismatch: err_count += 1, saturating at 255.
  - On mismatch with first_fail_valid=0: capture first_fail_vec=abc_out and first_fail_de=de_in, and set first_fail_valid=1.
  - Then, if abc_out != 7: abc_out += 1 -> DRIVE.
  - If abc_out == 7 and sweep != SWEEPS-1: abc_out wraps to 0, sweep += 1 -> DRIVE.
  - Otherwise -> DONE.
- DONE: done=1 and pass=(err_count==0). All results hold until the next start.
  - start=1 -> same clearing as from IDLE -> DRIVE.

start and abort:
- start is ignored while busy=1.
- abort has priority over every transition in every state. It -> IDLE with abc_out=0.
- After abort, err_count and first_fail_* keep their last values until the next start.
- start and abort high in the same cycle: abort wins, state=IDLE, and start is dropped.

Golden table, abc -> de:
- 000->11, 001->00, 010->11, 011->00
- 100->11, 101->00, 110->11, 111->10

Width rules and run length:
- abc_out wraps 7 -> 0 only inside a multi-sweep run.
- The sweep counter is 8 bits.
- Run length in cycles from start to done = SWEEPS*8*(SETTLE_CYCLES+2)+1.
- de_in is sampled only in SAMPLE; glitches on de_in in DRIVE/SETTLE have no effect.
- Outputs are registered; no combinational path from de_in to any output.

Test Plan:
1. Correct circuit, SETTLE_CYCLES=2, SWEEPS=1: pulse start -> abc_out steps 0..7, done rises 33 cycles after start, pass=1, err_count=0, first_fail_valid=0.
2. Faulty response at vector 3 (de_in forced 10 instead of 00): full run -> err_count=1, first_fail_vec=011, first_fail_de=10, pass=0.
3. de_in stuck at 11, SWEEPS=40: full run -> 4 mismatches per sweep gives 160 before saturation; err_count=160. Repeat with SWEEPS=100 -> err_count saturates at 255, first_fail_vec=001.
4. abort asserted during SETTLE of vector 5 -> next cycle state IDLE, abc_out=0, busy=0, done=0. A subsequent start clears err_count and runs cleanly to pass=1.
5. rst_n pulled low mid-sweep, asynchronously between clock edges -> all outputs 0 immediately; start after release gives a full clean run.
6. start pulsed while busy, and start+abort in the same cycle -> mid-run start has no effect (vector sequence unchanged); simultaneous start+abort leaves state IDLE.
